simple_io_responder: RTL and testbench

//  Device-side responder for the SIMPLE CPU's IN/OUT instructions. Buffers host-supplied

---
 rtl/simple_io_pkg.sv | 15 +
 rtl/io_fifo.sv | 71 +++++++
 rtl/simple_io_responder.sv | 96 +++++++++
 tb/tb_simple_io_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_io_pkg.sv
// Shared word width, default FIFO depth and occupancy-counter sizing for the
// SIMPLE CPU I/O responder.
package simple_io_pkg;

  localparam int DATA_W        = 16;
  localparam int DEFAULT_DEPTH = 8;

  // A counter that must hold 0..depth needs one bit more than the pointer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_DEPTH);

endpackage

// File: rtl/io_fifo.sv
// First-word-fall-through FIFO with a separate occupancy counter; head reads as
// zero when empty, and every output is a function of registered state only.
module io_fifo
  import simple_io_pkg::*;
#(
  parameter int DATA_W = simple_io_pkg::DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  // Guards use the state at the start of the cycle, so a pop on a full FIFO
  // frees no room for a push issued in the same cycle.
  assign w_do_push = push & ~w_full;
  assign w_do_pop  = pop & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = r_count;

endmodule

// File: rtl/simple_io_responder.sv
// Device-side responder for the SIMPLE CPU IN/OUT instructions: a host-fed input
// FIFO read by IN, an OUT-fed output FIFO drained by the host, plus sticky errors.
module simple_io_responder
  import simple_io_pkg::*;
#(
  parameter int DATA_W = simple_io_pkg::DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_in_req,
  output logic [DATA_W-1:0] io_in_data,
  output logic              io_in_stall,
  input  logic              io_out_req,
  input  logic [DATA_W-1:0] io_out_data,
  output logic              io_out_stall,
  input  logic              host_wr_valid,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ready,
  output logic              host_rd_valid,
  output logic [DATA_W-1:0] host_rd_data,
  input  logic              host_rd_ready,
  input  logic              clr_flags,
  output logic [CNT_W-1:0]  in_count,
  output logic [CNT_W-1:0]  out_count,
  output logic              underflow,
  output logic              overflow
);

  logic w_in_full;
  logic w_in_empty;
  logic w_out_full;
  logic w_out_empty;
  logic w_underflow_evt;
  logic w_overflow_evt;

  logic r_underflow;
  logic r_overflow;

  // Host -> CPU direction; the FIFO itself drops pushes when full and pops when empty.
  io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) in_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (host_wr_valid),
    .pop     (io_in_req),
    .wr_data (host_wr_data),
    .rd_data (io_in_data),
    .full    (w_in_full),
    .empty   (w_in_empty),
    .count   (in_count)
  );

  // CPU -> host direction.
  io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) out_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (io_out_req),
    .pop     (host_rd_ready),
    .wr_data (io_out_data),
    .rd_data (host_rd_data),
    .full    (w_out_full),
    .empty   (w_out_empty),
    .count   (out_count)
  );

  assign w_underflow_evt = io_in_req & w_in_empty;
  assign w_overflow_evt  = io_out_req & w_out_full;

  // A violation in the same cycle as clr_flags keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_underflow <= w_underflow_evt | (r_underflow & ~clr_flags);
      r_overflow  <= w_overflow_evt | (r_overflow & ~clr_flags);
    end
  end

  assign io_in_stall   = w_in_empty;
  assign io_out_stall  = w_out_full;
  assign host_wr_ready = ~w_in_full;
  assign host_rd_valid = ~w_out_empty;
  assign underflow     = r_underflow;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_simple_io_responder.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks every
// IN/host-read transfer; counts and flags are checked directly after each step.
module tb_simple_io_responder;

  logic        clk;
  logic        reset;
  logic        io_in_req;
  logic [15:0] io_in_data;
  logic        io_in_stall;
  logic        io_out_req;
  logic [15:0] io_out_data;
  logic        io_out_stall;
  logic        host_wr_valid;
  logic [15:0] host_wr_data;
  logic        host_wr_ready;
  logic        host_rd_valid;
  logic [15:0] host_rd_data;
  logic        host_rd_ready;
  logic        clr_flags;
  logic [3:0]  in_count;
  logic [3:0]  out_count;
  logic        underflow;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_in_q[$];
  logic [15:0] exp_out_q[$];

  simple_io_responder dut (
    .clk           (clk),
    .reset         (reset),
    .io_in_req     (io_in_req),
    .io_in_data    (io_in_data),
    .io_in_stall   (io_in_stall),
    .io_out_req    (io_out_req),
    .io_out_data   (io_out_data),
    .io_out_stall  (io_out_stall),
    .host_wr_valid (host_wr_valid),
    .host_wr_data  (host_wr_data),
    .host_wr_ready (host_wr_ready),
    .host_rd_valid (host_rd_valid),
    .host_rd_data  (host_rd_data),
    .host_rd_ready (host_rd_ready),
    .clr_flags     (clr_flags),
    .in_count      (in_count),
    .out_count     (out_count),
    .underflow     (underflow),
    .overflow      (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted IN or host read pops the matching scoreboard queue.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (io_in_req && !io_in_stall) begin
          if (exp_in_q.size() == 0) begin
            n_checks++;
            $display("FAIL in_unexpected: got %0h expected none", io_in_data);
          end else begin
            e = exp_in_q.pop_front();
            $display("IN   word %h (expected %h)", io_in_data, e);
            check("in_data", 32'(io_in_data), 32'(e));
          end
        end
        if (host_rd_valid && host_rd_ready) begin
          if (exp_out_q.size() == 0) begin
            n_checks++;
            $display("FAIL out_unexpected: got %0h expected none", host_rd_data);
          end else begin
            e = exp_out_q.pop_front();
            $display("READ word %h (expected %h)", host_rd_data, e);
            check("rd_data", 32'(host_rd_data), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    int m;
    int pushed;
    logic do_push;
    logic do_pop;
    logic [15:0] init_vals [3];
    init_vals[0] = 16'h0011;
    init_vals[1] = 16'h0022;
    init_vals[2] = 16'h0033;

    reset = 1'b1;
    io_in_req = 1'b0; io_out_req = 1'b0; io_out_data = '0;
    host_wr_valid = 1'b0; host_wr_data = '0; host_rd_ready = 1'b0; clr_flags = 1'b0;

    // 1: reset state
    tick(); tick();
    check("rst_in_count", 32'(in_count), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_in_stall", 32'(io_in_stall), 32'd1);
    check("rst_out_stall", 32'(io_out_stall), 32'd0);
    check("rst_wr_ready", 32'(host_wr_ready), 32'd1);
    check("rst_rd_valid", 32'(host_rd_valid), 32'd0);
    check("rst_flags", 32'({underflow, overflow}), 32'd0);
    check("rst_in_data", 32'(io_in_data), 32'h0000);
    reset = 1'b0;
    tick();

    // 2: host feeds three words, CPU consumes them in order
    host_wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_wr_data = init_vals[i];
      exp_in_q.push_back(init_vals[i]);
      tick();
    end
    host_wr_valid = 1'b0;
    check("t2_in_count", 32'(in_count), 32'd3);
    check("t2_head", 32'(io_in_data), 32'h0011);
    io_in_req = 1'b1;
    repeat (3) tick();
    io_in_req = 1'b0;
    check("t2_stall", 32'(io_in_stall), 32'd1);
    check("t2_in_count0", 32'(in_count), 32'd0);
    check("t2_underflow", 32'(underflow), 32'd0);

    // 3: fill output FIFO, overflow on the ninth word, drain
    io_out_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      io_out_data = 16'h0100 + 16'(i);
      exp_out_q.push_back(16'h0100 + 16'(i));
      tick();
    end
    check("t3_out_stall", 32'(io_out_stall), 32'd1);
    check("t3_out_count", 32'(out_count), 32'd8);
    io_out_data = 16'hBEEF;
    tick();
    io_out_req = 1'b0;
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_out_count_kept", 32'(out_count), 32'd8);
    host_rd_ready = 1'b1;
    repeat (8) tick();
    host_rd_ready = 1'b0;
    check("t3_drained", 32'(out_count), 32'd0);
    check("t3_rd_valid", 32'(host_rd_valid), 32'd0);
    check("t3_rd_zero", 32'(host_rd_data), 32'd0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("t3_clr", 32'(overflow), 32'd0);

    // 4: 20 words through each FIFO with random consumer, across pointer wrap
    m = 0; pushed = 0;
    for (int c = 0; c < 300 && (pushed < 20 || m > 0); c++) begin
      do_push = (pushed < 20) && (m < 8);
      do_pop  = (m > 0) && ($urandom_range(0, 2) == 0);
      host_wr_valid = do_push;
      host_wr_data  = 16'h1000 + 16'(pushed);
      io_in_req     = do_pop;
      if (do_push) exp_in_q.push_back(16'h1000 + 16'(pushed));
      tick();
      m = m + int'(do_push) - int'(do_pop);
      if (do_push) pushed++;
      check("t4_in_count", 32'(in_count), 32'(m));
    end
    host_wr_valid = 1'b0; io_in_req = 1'b0;
    check("t4_in_done", 32'(pushed), 32'd20);
    m = 0; pushed = 0;
    for (int c = 0; c < 300 && (pushed < 20 || m > 0); c++) begin
      do_push = (pushed < 20) && (m < 8);
      host_rd_ready = ($urandom_range(0, 2) == 0);
      do_pop  = (m > 0) && host_rd_ready;
      io_out_req  = do_push;
      io_out_data = 16'h2000 + 16'(pushed);
      if (do_push) exp_out_q.push_back(16'h2000 + 16'(pushed));
      tick();
      m = m + int'(do_push) - int'(do_pop);
      if (do_push) pushed++;
      check("t4_out_count", 32'(out_count), 32'(m));
    end
    io_out_req = 1'b0; host_rd_ready = 1'b0;
    check("t4_out_done", 32'(pushed), 32'd20);
    check("t4_flags", 32'({underflow, overflow}), 32'd0);

    // 5: simultaneous push+pop on full output FIFO and on empty input FIFO
    io_out_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      io_out_data = 16'h0300 + 16'(i);
      exp_out_q.push_back(16'h0300 + 16'(i));
      tick();
    end
    io_out_data = 16'hDEAD;
    host_rd_ready = 1'b1;
    tick();
    io_out_req = 1'b0;
    check("t5_out_count", 32'(out_count), 32'd7);
    check("t5_overflow", 32'(overflow), 32'd1);
    repeat (7) tick();
    host_rd_ready = 1'b0;
    check("t5_out_empty", 32'(out_count), 32'd0);
    host_wr_valid = 1'b1; host_wr_data = 16'h5555; io_in_req = 1'b1;
    exp_in_q.push_back(16'h5555);
    tick();
    host_wr_valid = 1'b0; io_in_req = 1'b0;
    check("t5_in_count", 32'(in_count), 32'd1);
    check("t5_underflow", 32'(underflow), 32'd1);
    check("t5_head", 32'(io_in_data), 32'h5555);
    io_in_req = 1'b1;
    tick();
    io_in_req = 1'b0;

    // 6: reset mid-drain, then clr_flags racing a violation
    io_out_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      io_out_data = 16'h0400 + 16'(i);
      exp_out_q.push_back(16'h0400 + 16'(i));
      tick();
    end
    io_out_req = 1'b0;
    host_rd_ready = 1'b1;
    tick();
    host_rd_ready = 1'b0;
    check("t6_pre_count", 32'(out_count), 32'd4);
    reset = 1'b1;
    exp_out_q.delete();
    exp_in_q.delete();
    tick();
    check("t6_out_count", 32'(out_count), 32'd0);
    check("t6_in_count", 32'(in_count), 32'd0);
    check("t6_rd_valid", 32'(host_rd_valid), 32'd0);
    check("t6_rd_data", 32'(host_rd_data), 32'd0);
    check("t6_flags", 32'({underflow, overflow}), 32'd0);
    check("t6_stalls", 32'({io_in_stall, io_out_stall}), 32'b10);
    check("t6_wr_ready", 32'(host_wr_ready), 32'd1);
    reset = 1'b0;
    tick();
    io_in_req = 1'b1; clr_flags = 1'b1;
    tick();
    io_in_req = 1'b0; clr_flags = 1'b0;
    check("t6_clr_race", 32'(underflow), 32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("t6_clr", 32'(underflow), 32'd0);

    check("in_queue_empty", 32'(exp_in_q.size()), 32'd0);
    check("out_queue_empty", 32'(exp_out_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
